// File: rtl/iomem_dbg_pkg.sv
// Shared types and constants for the byte-stream iomem debug master.
package iomem_dbg_pkg;

  typedef enum logic [2:0] {
    S_OPC  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_STAT = 3'd4,
    S_RDAT = 3'd5
  } state_e;

  // Opcode byte layout: [7] write, [6:4] reserved zero, [3:0] write strobes
  localparam int unsigned OP_WR_BIT     = 7;
  localparam int unsigned OP_RSVD_MSB   = 6;
  localparam int unsigned OP_RSVD_LSB   = 4;
  localparam int unsigned OP_WSTRB_LSB  = 0;
  localparam int unsigned OP_WSTRB_W    = 4;

  localparam int unsigned ADDR_BYTES    = 4;
  localparam int unsigned DATA_BYTES    = 4;
  localparam int unsigned RDAT_BYTES    = 4;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BADOP   = 8'h02;

  // Reserved bits set, read with strobes, or write with no strobes.
  function automatic logic opc_bad(input logic [7:0] op);
    logic [OP_WSTRB_W-1:0] strb;
    logic                  rsvd;
    strb = op[OP_WSTRB_LSB +: OP_WSTRB_W];
    rsvd = |op[OP_RSVD_MSB:OP_RSVD_LSB];
    return rsvd || (op[OP_WR_BIT] ? (strb == '0) : (strb != '0));
  endfunction

endpackage

// File: rtl/iomem_dbg_master.sv
// Byte-framed command stream to single iomem bus transactions, with timeout
// and a status/read-data response stream.
module iomem_dbg_master
  import iomem_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  localparam int unsigned TMO_W = 16;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        iomem_valid_q, iomem_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;

  logic cmd_fire;
  logic rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    wstrb_d       = wstrb_q;
    is_wr_d       = is_wr_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    iomem_valid_d = iomem_valid_q;

    unique case (state_q)
      S_OPC: begin
        if (cmd_fire) begin
          if (opc_bad(cmd_data)) begin
            state_d     = S_STAT;
            is_wr_d     = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = ST_BADOP;
          end else begin
            state_d = S_ADDR;
            idx_d   = 2'd0;
            is_wr_d = cmd_data[OP_WR_BIT];
            wstrb_d = cmd_data[OP_WR_BIT] ? cmd_data[OP_WSTRB_LSB +: OP_WSTRB_W] : 4'h0;
            wdata_d = 32'h0;
          end
        end
      end
      S_ADDR: begin
        if (cmd_fire) begin
          addr_d = {cmd_data, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'(ADDR_BYTES - 1)) begin
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d       = S_BUS;
              iomem_valid_d = 1'b1;
              tmo_d         = '0;
            end
          end
        end
      end
      S_DATA: begin
        if (cmd_fire) begin
          wdata_d = {cmd_data, wdata_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'(DATA_BYTES - 1)) begin
            state_d       = S_BUS;
            iomem_valid_d = 1'b1;
            tmo_d         = '0;
          end
        end
      end
      S_BUS: begin
        // A ready in the limit cycle takes priority over the timeout.
        if (iomem_ready) begin
          state_d       = S_STAT;
          iomem_valid_d = 1'b0;
          rdata_d       = iomem_rdata;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = ST_OK;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_STAT;
          iomem_valid_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_STAT: begin
        if (rsp_fire) begin
          if (!is_wr_q && (rsp_data_q == ST_OK)) begin
            state_d    = S_RDAT;
            idx_d      = 2'd0;
            rsp_data_d = rdata_q[7:0];
            rdata_d    = {8'h00, rdata_q[31:8]};
          end else begin
            state_d     = S_OPC;
            rsp_valid_d = 1'b0;
          end
        end
      end
      S_RDAT: begin
        if (rsp_fire) begin
          if (idx_q == 2'(RDAT_BYTES - 1)) begin
            state_d     = S_OPC;
            rsp_valid_d = 1'b0;
          end else begin
            idx_d      = idx_q + 2'd1;
            rsp_data_d = rdata_q[7:0];
            rdata_d    = {8'h00, rdata_q[31:8]};
          end
        end
      end
      default: begin
        state_d       = S_OPC;
        rsp_valid_d   = 1'b0;
        iomem_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_OPC) || (state_d == S_ADDR) || (state_d == S_DATA);
    busy_d      = (state_d != S_OPC);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_OPC;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      rdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      is_wr_q       <= 1'b0;
      idx_q         <= 2'd0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      iomem_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      wstrb_q       <= wstrb_d;
      is_wr_q       <= is_wr_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      iomem_valid_q <= iomem_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign iomem_valid = iomem_valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_iomem_dbg_master.sv
// Directed bench for iomem_dbg_master: write, read, timeout, bad opcode,
// response backpressure and asynchronous reset mid-frame / mid-bus.
module tb_iomem_dbg_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  iomem_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus responder: asserts ready once valid has been high rd_lat cycles.
  logic        rsp_en;
  int          rd_lat;
  logic [31:0] rd_value;
  int          vcnt;
  int          last_vcnt;
  logic        unstable;
  logic [31:0] a0, w0;
  logic [3:0]  s0;

  initial begin
    iomem_ready = 1'b0;
    iomem_rdata = 32'hA5A5A5A5;
    vcnt = 0;
    last_vcnt = 0;
    unstable = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (iomem_valid === 1'b1) begin
        if (vcnt == 0) begin
          a0 = iomem_addr; w0 = iomem_wdata; s0 = iomem_wstrb;
        end else if (iomem_addr !== a0 || iomem_wdata !== w0 || iomem_wstrb !== s0) begin
          unstable = 1'b1;
        end
        vcnt++;
        iomem_ready = rsp_en && (vcnt >= rd_lat);
      end else begin
        if (vcnt != 0) last_vcnt = vcnt;
        vcnt = 0;
        iomem_ready = 1'b0;
      end
      iomem_rdata = iomem_ready ? rd_value : 32'hA5A5A5A5;
    end
  end

  // Counts every accepted command byte.
  int acc_cnt = 0;
  always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt++;

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!cmd_ready) check_eq("cmd_accept_tmo", 32'(cmd_ready), 32'd1);
    else begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (op[7]) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  // Receive one response byte after bp cycles of held-off rsp_ready.
  task automatic rx_check(input string tag, input int bp, input logic [7:0] exp, input logic chk_rate);
    int   w;
    logic [7:0] d0;
    logic stable;
    w = 0;
    stable = 1'b1;
    rsp_ready = 1'b0;
    while (!rsp_valid && w < 200) begin @(posedge clk); #1; w++; end
    if (!rsp_valid) begin
      check_eq("rsp_valid_tmo", 32'(rsp_valid), 32'd1);
      return;
    end
    if (chk_rate) check_eq("rsp_rate", 32'(w), 32'd0);
    d0 = rsp_data;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0) stable = 1'b0;
    end
    if (bp > 0) check_eq("rsp_hold", 32'(stable), 32'd1);
    check_eq(tag, 32'(rsp_data), 32'(exp));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, {29'h0, cmd_ready, rsp_valid, busy}, {29'h0, 1'b1, 1'b0, 1'b0});
  endtask

  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
    rsp_en = 1'b1; rd_lat = 1; rd_value = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    check_eq("rst_wstrb", 32'(iomem_wstrb), 32'd0);
    check_eq("rst_addr", iomem_addr, 32'd0);
    check_eq("rst_wdata", iomem_wdata, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Write 0xDEADBEEF to 0x03000000, ready one cycle after valid
    rd_lat = 2; unstable = 1'b0;
    send_frame(8'h8F, 32'h03000000, 32'hDEADBEEF);
    check_eq("wr_valid", 32'(iomem_valid), 32'd1);
    check_eq("wr_addr", iomem_addr, 32'h03000000);
    check_eq("wr_wstrb", 32'(iomem_wstrb), 32'hF);
    check_eq("wr_wdata", iomem_wdata, 32'hDEADBEEF);
    check_eq("wr_cmd_ready_bus", 32'(cmd_ready), 32'd0);
    rx_check("wr_status", 0, 8'h00, 1'b0);
    check_eq("wr_valid_cycles", 32'(last_vcnt), 32'd2);
    check_eq("wr_stable", 32'(unstable), 32'd0);
    check_idle("wr_idle");

    // Read 0x06000000 returning 3
    rd_lat = 1; rd_value = 32'h00000003;
    send_frame(8'h00, 32'h06000000, 32'h0);
    check_eq("rd_wstrb", 32'(iomem_wstrb), 32'd0);
    check_eq("rd_wdata", iomem_wdata, 32'd0);
    check_eq("rd_addr", iomem_addr, 32'h06000000);
    check_eq("rd_busy", 32'(busy), 32'd1);
    rx_check("rd_status", 0, 8'h00, 1'b0);
    rx_check("rd_b0", 0, 8'h03, 1'b1);
    rx_check("rd_b1", 0, 8'h00, 1'b1);
    rx_check("rd_b2", 0, 8'h00, 1'b1);
    rx_check("rd_b3", 0, 8'h00, 1'b1);
    check_idle("rd_idle");

    // Timeout: responder never ready
    rsp_en = 1'b0;
    send_frame(8'h00, 32'h10000000, 32'h0);
    rx_check("to_status", 0, 8'h01, 1'b0);
    check_eq("to_valid_cycles", 32'(last_vcnt), 32'd8);
    check_idle("to_idle");
    rsp_en = 1'b1;

    // Bad opcodes, then a normal read
    send_byte(8'h30);
    check_eq("bad_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("bad_rsp_valid", 32'(rsp_valid), 32'd1);
    rx_check("bad30_status", 0, 8'h02, 1'b0);
    check_idle("bad30_idle");
    send_byte(8'h80);
    rx_check("bad80_status", 0, 8'h02, 1'b0);
    send_byte(8'h05);
    rx_check("bad05_status", 0, 8'h02, 1'b0);
    rd_value = 32'h12345678;
    send_frame(8'h00, 32'h20000000, 32'h0);
    check_eq("bad_rd_addr", iomem_addr, 32'h20000000);
    rx_check("bad_rd_status", 0, 8'h00, 1'b0);
    rx_check("bad_rd_b0", 0, 8'h78, 1'b1);
    rx_check("bad_rd_b1", 0, 8'h56, 1'b1);
    rx_check("bad_rd_b2", 0, 8'h34, 1'b1);
    rx_check("bad_rd_b3", 0, 8'h12, 1'b1);

    // Backpressure with command bytes offered during BUS/response
    rd_lat = 4; rd_value = 32'hCAFEF00D;
    send_frame(8'h00, 32'h30000000, 32'h0);
    base = acc_cnt;
    cmd_valid = 1'b1; cmd_data = 8'hAA;
    rx_check("bp_status", 5, 8'h00, 1'b0);
    check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    rx_check("bp_b0", 5, 8'h0D, 1'b0);
    rx_check("bp_b1", 5, 8'hF0, 1'b0);
    rx_check("bp_b2", 5, 8'hFE, 1'b0);
    cmd_valid = 1'b0;
    rx_check("bp_b3", 5, 8'hCA, 1'b0);
    check_eq("bp_no_accept", 32'(acc_cnt - base), 32'd0);
    check_idle("bp_idle");

    // Reset mid-ADDR
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("mid_addr_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("mid_addr_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid_addr_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Reset mid-BUS
    rsp_en = 1'b0;
    send_frame(8'h00, 32'h44000000, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("mid_bus_valid", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("mid_bus_rst_valid", 32'(iomem_valid), 32'd0);
    check_eq("mid_bus_rst_addr", iomem_addr, 32'd0);
    check_eq("mid_bus_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    rsp_en = 1'b1; rd_lat = 2;
    @(posedge clk); #1;

    // Full write after resets
    send_frame(8'h81, 32'h02000000, 32'h44332211);
    check_eq("post_addr", iomem_addr, 32'h02000000);
    check_eq("post_wdata", iomem_wdata, 32'h44332211);
    check_eq("post_wstrb", 32'(iomem_wstrb), 32'h1);
    rx_check("post_status", 0, 8'h00, 1'b0);
    check_eq("post_valid_cycles", 32'(last_vcnt), 32'd2);
    check_idle("post_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
